seg_display_arbiter: RTL

//   Time-sliced arbiter that shares the single 7-segment output among NUM_SRC pattern sources
//   (seconds counter, status/error codes, user message, ...).

---
 rtl/seg_arb_pkg.sv | 55 +++++
 rtl/tick_prescaler.sv | 44 ++++
 rtl/seg_display_arbiter.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/seg_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg_arb_pkg
//  Purpose  : Shared types, constants and the round-robin pick helper for the
//             7-segment display arbiter.
//  Contents : arb_state_e  - arbiter FSM states {IDLE, SHOW, GAP}
//             SEG_W        - segment vector width
//             SEG_BLANK    - all-segments-off pattern
//             rr_pick()    - round-robin winner search
//  Revision : 1.0  initial release
// ============================================================================
package seg_arb_pkg;

    localparam int SEG_W   = 7;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

    // Upper bound on requesters; indices are carried at this fixed width so
    // the pick helper can live here independent of the instance parameter.
    localparam int MAX_SRC = 8;
    localparam int IDX_W   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // Search req starting at ptr+1 (mod n) and return the first set bit.
    // Only the lowest n bits of req are considered.
    function automatic rr_pick_t rr_pick(
        input logic [MAX_SRC-1:0] req,
        input logic [IDX_W-1:0]   ptr,
        input int                 n
    );
        rr_pick_t         res;
        logic [IDX_W-1:0] cand;
        res.valid = 1'b0;
        res.idx   = '0;
        for (int k = 1; k <= MAX_SRC; k++) begin
            cand = IDX_W'((int'(ptr) + k) % n);
            if ((k <= n) && !res.valid && req[cand]) begin
                res.valid = 1'b1;
                res.idx   = cand;
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
//  Module   : tick_prescaler
//  Purpose  : Free-running divider producing a one-cycle tick every TICK_DIV
//             clocks. Counts 0..TICK_DIV-1; tick is high while the count
//             sits at TICK_DIV-1.
//  Ports    : clk  in  1  rising-edge clock
//             rst  in  1  synchronous active-high reset (count -> 0)
//             tick out 1  dwell tick strobe
//  Revision : 1.0  initial release
// ============================================================================
module tick_prescaler #(
    parameter int TICK_DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/seg_display_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : seg_display_arbiter
//  Purpose  : Time-sliced round-robin arbiter sharing one 7-segment output
//             among NUM_SRC pattern sources. Each owner holds the display for
//             DWELL_TICKS ticks, with a blank gap between owners. Source 0 can
//             optionally preempt any other owner.
//  Ports    : clk      in  1          rising-edge clock
//             rst      in  1          synchronous active-high reset
//             req      in  NUM_SRC    per-source level request
//             seg_in   in  7*NUM_SRC  patterns, source i at [7*i+6:7*i]
//             grant    out NUM_SRC    one-hot owner, zero when none
//             seg_out  out 7          registered segment drive, 0 = blank
//             busy     out 1          high in SHOW or GAP
//  Revision : 1.0  initial release
// ============================================================================
module seg_display_arbiter
    import seg_arb_pkg::*;
#(
    parameter int NUM_SRC     = 4,
    parameter int TICK_DIV    = 1000,
    parameter int DWELL_TICKS = 8,
    parameter int GAP_TICKS   = 1,
    parameter int PRIO0       = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_SRC-1:0]       req,
    input  logic [SEG_W*NUM_SRC-1:0] seg_in,
    output logic [NUM_SRC-1:0]       grant,
    output logic [SEG_W-1:0]         seg_out,
    output logic                     busy
);

    // The dwell counter is shared between SHOW (dwell ticks) and GAP (gap
    // ticks), so it is sized for the larger of the two.
    localparam int DMAX = (DWELL_TICKS > GAP_TICKS) ? DWELL_TICKS : GAP_TICKS;
    localparam int DW   = (DMAX > 1) ? $clog2(DMAX) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_TICKS - 1);
    localparam logic [DW-1:0] GAP_LAST   = DW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
    localparam logic [IDX_W-1:0] RR_INIT = IDX_W'(NUM_SRC - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    arb_state_e         state_q,  state_d;
    logic [IDX_W-1:0]   owner_q,  owner_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [DW-1:0]      dwell_q,  dwell_d;
    logic [NUM_SRC-1:0] grant_q,  grant_d;
    logic [SEG_W-1:0]   seg_q,    seg_d;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    logic                  tick;
    logic [MAX_SRC-1:0]    req_ext;
    logic [SEG_W-1:0]      pat [MAX_SRC];
    logic [NUM_SRC-1:0]    owner_mask;
    logic                  owner_req;
    logic                  other_pend;
    logic                  preempt;
    logic                  gap_done;
    rr_pick_t              pick;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Unpack the pattern bus into an 8-entry table; unused slots read blank
    // so the owner index can stay at the package's fixed width.
    for (genvar gi = 0; gi < MAX_SRC; gi++) begin : g_pat
        if (gi < NUM_SRC) begin : g_src
            assign pat[gi] = seg_in[SEG_W*gi +: SEG_W];
        end else begin : g_pad
            assign pat[gi] = SEG_BLANK;
        end
    end

    always_comb begin
        req_ext              = '0;
        req_ext[NUM_SRC-1:0] = req;
    end

    always_comb begin
        owner_mask = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            owner_mask[i] = (owner_q == IDX_W'(i));
        end
    end

    assign owner_req  = req_ext[owner_q];
    assign other_pend = |(req & ~owner_mask);
    assign pick       = rr_pick(req_ext, rr_ptr_q, NUM_SRC);
    // In GAP owner_q still names the previous owner, which is what the
    // preempt test compares against.
    assign preempt    = (PRIO0 != 0) && req[0] && (owner_q != '0);
    assign gap_done   = (GAP_TICKS == 0) ? 1'b1 : (tick && (dwell_q == GAP_LAST));

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        dwell_d  = dwell_q;

        case (state_q)
            IDLE: begin
                if (pick.valid) begin
                    state_d  = SHOW;
                    owner_d  = pick.idx;
                    rr_ptr_d = pick.idx;
                    dwell_d  = '0;
                end
            end

            SHOW: begin
                // Preempt outranks a drop, and a drop outranks expiry, so a
                // drop on the expiry tick yields exactly one gap.
                if (preempt) begin
                    owner_d = '0;
                    dwell_d = '0;
                end else if (!owner_req) begin
                    state_d = GAP;
                    dwell_d = '0;
                end else if (tick) begin
                    if (dwell_q == DWELL_LAST) begin
                        dwell_d = '0;
                        if (other_pend) begin
                            state_d = GAP;
                        end
                    end else begin
                        dwell_d = dwell_q + DW'(1);
                    end
                end
            end

            GAP: begin
                if (preempt) begin
                    state_d = SHOW;
                    owner_d = '0;
                    dwell_d = '0;
                end else if (gap_done) begin
                    dwell_d = '0;
                    if (pick.valid) begin
                        state_d  = SHOW;
                        owner_d  = pick.idx;
                        rr_ptr_d = pick.idx;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (tick) begin
                    dwell_d = dwell_q + DW'(1);
                end
            end

            default: begin
                state_d = IDLE;
                dwell_d = '0;
            end
        endcase
    end

    // Outputs are computed from the next state so grant and seg_out switch
    // on the same edge as the owner does.
    always_comb begin
        grant_d = '0;
        seg_d   = SEG_BLANK;
        if (state_d == SHOW) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                grant_d[i] = (owner_d == IDX_W'(i));
            end
            seg_d = pat[owner_d];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= RR_INIT;
            dwell_q  <= '0;
            grant_q  <= '0;
            seg_q    <= SEG_BLANK;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            dwell_q  <= dwell_d;
            grant_q  <= grant_d;
            seg_q    <= seg_d;
        end
    end

    assign grant   = grant_q;
    assign seg_out = seg_q;
    assign busy    = (state_q != IDLE);

endmodule
`default_nettype wire
